// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RV immediate generator with a 2-entry valid/ready output FIFO
// Optional Z-type CSR immediate (src 101) is enabled by defining IMM_GEN_ZICSR_EN.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_instr,
  input  logic [2:0]       i_imm_src,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [XLEN-1:0]  o_imm,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_illegal
);
  logic [XLEN-1:0]  r_imm [2];
  logic [TAG_W-1:0] r_tag [2];
  logic [1:0]       r_ill;
  logic [XLEN-1:0]  r_last_imm;
  logic [TAG_W-1:0] r_last_tag;
  logic             r_last_ill;
  logic             r_rd, r_wr;
  logic [1:0]       r_cnt;
  logic [31:0]      w_imm32;
  logic [XLEN-1:0]  w_imm;
  logic             w_z, w_ill, w_push, w_pop, w_unused;
  logic             w_s;

  assign w_s = i_instr[31];
  assign w_imm32 = (i_imm_src == 3'd0) ? {{20{w_s}}, i_instr[31:20]} :
                   (i_imm_src == 3'd1) ? {{20{w_s}}, i_instr[31:25], i_instr[11:7]} :
                   (i_imm_src == 3'd2) ? {{19{w_s}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0} :
                   (i_imm_src == 3'd3) ? {{11{w_s}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0} :
                   (i_imm_src == 3'd4) ? {i_instr[31:12], 12'h000} : 32'h0;
`ifdef IMM_GEN_ZICSR_EN
  assign w_z = (i_imm_src == 3'b101);
`else
  assign w_z = 1'b0;
`endif
  assign w_ill = (i_imm_src > 3'd4) & ~w_z;
  assign w_imm = w_ill ? '0 : w_z ? XLEN'(i_instr[19:15]) : XLEN'($signed(w_imm32));
  assign w_unused = &{1'b0, i_instr[6:0]};

  assign o_ready   = (r_cnt < 2'd2) & i_rst_n;
  assign o_valid   = (r_cnt != 2'd0);
  assign w_push    = i_valid & o_ready;
  assign w_pop     = o_valid & i_ready;
  // Once empty, outputs fall back to the last value shown rather than stale slot data
  assign o_imm     = o_valid ? r_imm[r_rd] : r_last_imm;
  assign o_tag     = o_valid ? r_tag[r_rd] : r_last_tag;
  assign o_illegal = o_valid ? r_ill[r_rd] : r_last_ill;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt      <= '0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_imm[0]   <= '0;
      r_imm[1]   <= '0;
      r_tag[0]   <= '0;
      r_tag[1]   <= '0;
      r_ill      <= '0;
      r_last_imm <= '0;
      r_last_tag <= '0;
      r_last_ill <= 1'b0;
    end else begin
      r_last_imm <= o_imm;
      r_last_tag <= o_tag;
      r_last_ill <= o_illegal;
      if (i_flush) begin
        r_cnt <= '0;
        r_rd  <= 1'b0;
        r_wr  <= 1'b0;
      end else begin
        if (w_push) begin
          r_imm[r_wr] <= w_imm;
          r_tag[r_wr] <= i_tag;
          r_ill[r_wr] <= w_ill;
          r_wr        <= ~r_wr;
        end
        if (w_pop) r_rd <= ~r_rd;
        r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
      end
    end
  end
endmodule
